// File: rtl/reg_read_stage.sv
// Register-read stage: operand fetch with EX/MEM/WB forwarding, load-use bubbling,
// immediate formation, and expansion of LM/SM into one micro-op per masked register.
module reg_read_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [3:0]  opcode_in,
  input  logic [2:0]  ra_in,
  input  logic [2:0]  rb_in,
  input  logic [2:0]  rc_in,
  input  logic [5:0]  imm6_in,
  input  logic [8:0]  imm9_in,
  input  logic [2:0]  ccz_in,
  input  logic [15:0] pc_in,
  input  logic        regsel_in,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic        ex_wr_en,
  input  logic [2:0]  ex_wr_addr,
  input  logic [15:0] ex_wr_data,
  input  logic        ex_is_load,
  input  logic        mem_wr_en,
  input  logic [2:0]  mem_wr_addr,
  input  logic [15:0] mem_wr_data,
  output logic [3:0]  opcode_out,
  output logic [2:0]  rc_out,
  output logic [15:0] ra_data,
  output logic [15:0] rb_data,
  output logic [15:0] imm_out,
  output logic [2:0]  ccz_out,
  output logic [15:0] pc_out,
  output logic        valid_out,
  output logic        stall_out,
  output logic        lmsm_busy
);

  localparam logic [0:0]  IDLE  = 1'b0;
  localparam logic [0:0]  MULTI = 1'b1;
  localparam logic [3:0]  OP_LM = 4'd6;
  localparam logic [3:0]  OP_SM = 4'd7;
  // Bit n set when opcode n actually reads that source register.
  localparam logic [15:0] RA_READERS = 16'h27E7;
  localparam logic [15:0] RB_READERS = 16'h1735;

  logic [15:0] rf [8];
  logic [15:0] fwd_val [8];
  logic [0:0]  state_reg;
  logic [7:0]  mask_reg;
  logic [2:0]  k_reg;
  logic [15:0] base_reg;
  logic [15:0] pc_reg;
  logic [3:0]  op_reg;

  logic [15:0] ra_fwd;
  logic [15:0] rb_fwd;
  logic        is_lmsm;
  logic        load_use;
  logic        lmsm_start;
  logic [15:0] imm_val;
  logic [2:0]  low_idx;
  logic [7:0]  mask_rest;
  logic        last_uop;

  // Every register gets its fully forwarded value; WB term gives write-through.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fwd
      assign fwd_val[gi] = (ex_wr_en  && ex_wr_addr  == 3'(gi)) ? ex_wr_data  :
                           (mem_wr_en && mem_wr_addr == 3'(gi)) ? mem_wr_data :
                           (wb_en     && wb_addr     == 3'(gi)) ? wb_data     :
                           rf[gi];
    end
  endgenerate

  assign ra_fwd = fwd_val[ra_in];
  assign rb_fwd = fwd_val[rb_in];

  assign is_lmsm  = (opcode_in == OP_LM) || (opcode_in == OP_SM);
  assign load_use = ex_is_load && ex_wr_en &&
                    ((RA_READERS[opcode_in] && ex_wr_addr == ra_in) ||
                     (RB_READERS[opcode_in] && ex_wr_addr == rb_in));
  assign lmsm_start = valid_in && is_lmsm && (imm9_in[7:0] != 8'd0) && !load_use;

  always_comb begin
    case (opcode_in)
      4'd1, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd12: imm_val = {{10{imm6_in[5]}}, imm6_in};
      4'd3:    imm_val = {7'd0, imm9_in};
      4'd13:   imm_val = {{7{imm9_in[8]}}, imm9_in};
      default: imm_val = 16'd0;
    endcase
  end

  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_reg[i]) low_idx = 3'(i);
    end
  end

  assign mask_rest = mask_reg & ~(8'd1 << low_idx);
  assign last_uop  = (mask_rest == 8'd0);

  // Upstream is held from LM/SM acceptance until the final micro-op is being emitted.
  assign stall_out = !flush && ((state_reg == MULTI) ? !last_uop : (load_use || lmsm_start));
  assign lmsm_busy = !flush && ((state_reg == MULTI) || lmsm_start);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
      state_reg  <= IDLE;
      mask_reg   <= 8'd0;
      k_reg      <= 3'd0;
      base_reg   <= 16'd0;
      pc_reg     <= 16'd0;
      op_reg     <= 4'd0;
      opcode_out <= 4'd0;
      rc_out     <= 3'd0;
      ra_data    <= 16'd0;
      rb_data    <= 16'd0;
      imm_out    <= 16'd0;
      ccz_out    <= 3'd0;
      pc_out     <= 16'd0;
      valid_out  <= 1'b0;
    end else begin
      if (wb_en) rf[wb_addr] <= wb_data;

      if (flush) begin
        valid_out <= 1'b0;
        state_reg <= IDLE;
        mask_reg  <= 8'd0;
        k_reg     <= 3'd0;
      end else if (en) begin
        if (state_reg == MULTI) begin
          valid_out  <= 1'b1;
          opcode_out <= op_reg;
          rc_out     <= low_idx;
          ra_data    <= base_reg;
          rb_data    <= (op_reg == OP_SM) ? fwd_val[low_idx] : 16'd0;
          imm_out    <= {12'd0, k_reg, 1'b0};
          ccz_out    <= 3'd0;
          pc_out     <= pc_reg;
          mask_reg   <= mask_rest;
          k_reg      <= k_reg + 3'd1;
          if (last_uop) state_reg <= IDLE;
        end else if (load_use) begin
          valid_out <= 1'b0;
        end else begin
          opcode_out <= opcode_in;
          rc_out     <= rc_in;
          ra_data    <= regsel_in ? ra_fwd : 16'd0;
          rb_data    <= regsel_in ? rb_fwd : 16'd0;
          imm_out    <= imm_val;
          ccz_out    <= ccz_in;
          pc_out     <= pc_in;
          // LM/SM never issue as themselves; they expand or bubble.
          valid_out  <= valid_in && !is_lmsm;
          if (lmsm_start) begin
            state_reg <= MULTI;
            mask_reg  <= imm9_in[7:0];
            k_reg     <= 3'd0;
            base_reg  <= ra_fwd;
            op_reg    <= opcode_in;
            pc_reg    <= pc_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Self-checking bench for reg_read_stage: directed scenarios plus randomized
// single-issue traffic compared against a behavioural register/forwarding model.
module tb_reg_read_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en, flush, valid_in, regsel_in;
  logic [3:0]  opcode_in;
  logic [2:0]  ra_in, rb_in, rc_in, ccz_in;
  logic [5:0]  imm6_in;
  logic [8:0]  imm9_in;
  logic [15:0] pc_in;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_wr_en, ex_is_load;
  logic [2:0]  ex_wr_addr;
  logic [15:0] ex_wr_data;
  logic        mem_wr_en;
  logic [2:0]  mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic [3:0]  opcode_out;
  logic [2:0]  rc_out, ccz_out;
  logic [15:0] ra_data, rb_data, imm_out, pc_out;
  logic        valid_out, stall_out, lmsm_busy;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] ref_rf [8];

  always #5 clk = ~clk;

  reg_read_stage dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in),
    .opcode_in(opcode_in), .ra_in(ra_in), .rb_in(rb_in), .rc_in(rc_in),
    .imm6_in(imm6_in), .imm9_in(imm9_in), .ccz_in(ccz_in), .pc_in(pc_in),
    .regsel_in(regsel_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .ex_is_load(ex_is_load), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .opcode_out(opcode_out), .rc_out(rc_out),
    .ra_data(ra_data), .rb_data(rb_data), .imm_out(imm_out), .ccz_out(ccz_out),
    .pc_out(pc_out), .valid_out(valid_out), .stall_out(stall_out), .lmsm_busy(lmsm_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    en = 1'b1; flush = 1'b0; valid_in = 1'b0; regsel_in = 1'b0;
    opcode_in = 4'd0; ra_in = 3'd0; rb_in = 3'd0; rc_in = 3'd0; ccz_in = 3'd0;
    imm6_in = 6'd0; imm9_in = 9'd0; pc_in = 16'd0;
    wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'd0;
    ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_addr = 3'd0; ex_wr_data = 16'd0;
    mem_wr_en = 1'b0; mem_wr_addr = 3'd0; mem_wr_data = 16'd0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
    ref_rf[a] = d;
  endtask

  // Model: newest in-flight producer wins, else the architectural file.
  function automatic logic [15:0] m_fwd(input logic [2:0] a);
    if (ex_wr_en && ex_wr_addr == a) return ex_wr_data;
    if (mem_wr_en && mem_wr_addr == a) return mem_wr_data;
    if (wb_en && wb_addr == a) return wb_data;
    return ref_rf[a];
  endfunction

  function automatic logic [15:0] m_imm(input logic [3:0] op, input logic [5:0] i6, input logic [8:0] i9);
    if (op inside {4'd1, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd12}) return 16'($signed(i6));
    if (op == 4'd3) return 16'(i9);
    if (op == 4'd13) return 16'($signed(i9));
    return 16'd0;
  endfunction

  function automatic logic m_load_use();
    logic rd_a, rd_b;
    rd_a = opcode_in inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13};
    rd_b = opcode_in inside {4'd0, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd12};
    return ex_is_load && ex_wr_en &&
           ((rd_a && ex_wr_addr == ra_in) || (rd_b && ex_wr_addr == rb_in));
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'd0;
    vectors++;
    if ({opcode_out, rc_out, ra_data, rb_data, imm_out, ccz_out, pc_out, valid_out} !== 75'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h required 0",
               {opcode_out, rc_out, ra_data, rb_data, imm_out, ccz_out, pc_out, valid_out});
    end
    vectors++;
    if ({stall_out, lmsm_busy} !== 2'b00) begin
      miscompares++; $display("FAIL reset_stall_busy got %b required 00", {stall_out, lmsm_busy});
    end
    $display("test_reset done");
  endtask

  task automatic test_forwarding();
    logic [15:0] exp_v [4] = '{16'd9, 16'd7, 16'd5, 16'h0B0B};
    wb_write(3'd2, 16'd5);
    opcode_in = 4'd0; ra_in = 3'd2; rb_in = 3'd0; regsel_in = 1'b1; valid_in = 1'b1;
    mem_wr_en = 1'b1; mem_wr_addr = 3'd2; mem_wr_data = 16'd7;
    ex_wr_en = 1'b1; ex_wr_addr = 3'd2; ex_wr_data = 16'd9;
    for (int s = 0; s < 4; s++) begin
      if (s == 1) ex_wr_en = 1'b0;
      if (s == 2) mem_wr_en = 1'b0;
      if (s == 3) begin wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h0B0B; end
      tick();
      vectors++;
      if (ra_data !== exp_v[s] || valid_out !== 1'b1) begin
        miscompares++;
        $display("FAIL fwd_step%0d ra_data=%h valid=%b required %h/1", s, ra_data, valid_out, exp_v[s]);
      end
      $display("fwd step %0d ra_data=%h", s, ra_data);
    end
    wb_en = 1'b0; ref_rf[2] = 16'h0B0B;
    tick();
    vectors++;
    if (ra_data !== 16'h0B0B) begin
      miscompares++; $display("FAIL fwd_file_after_wb got %h required 0b0b", ra_data);
    end
    regsel_in = 1'b0;
    tick();
    vectors++;
    if ({ra_data, rb_data} !== 32'd0) begin
      miscompares++; $display("FAIL regsel_zero got %h/%h required 0/0", ra_data, rb_data);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    wb_write(3'd3, 16'h0033);
    opcode_in = 4'd0; ra_in = 3'd1; rb_in = 3'd3; rc_in = 3'd4; pc_in = 16'h0040;
    regsel_in = 1'b1; valid_in = 1'b1;
    ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 3'd3; ex_wr_data = 16'hDEAD;
    #1;
    vectors++;
    if (stall_out !== 1'b1) begin miscompares++; $display("FAIL load_use_stall got %b required 1", stall_out); end
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL load_use_bubble got %b required 0", valid_out); end
    ex_is_load = 1'b0; ex_wr_en = 1'b0;
    #1;
    vectors++;
    if (stall_out !== 1'b0) begin miscompares++; $display("FAIL load_use_release got %b required 0", stall_out); end
    tick();
    vectors++;
    if ({valid_out, rb_data, rc_out, pc_out} !== {1'b1, 16'h0033, 3'd4, 16'h0040}) begin
      miscompares++;
      $display("FAIL load_use_retry got v=%b rb=%h rc=%0d pc=%h required 1/0033/4/0040",
               valid_out, rb_data, rc_out, pc_out);
    end
    // LLI reads no register, so a pending load to ra must not stall it.
    opcode_in = 4'd3; ra_in = 3'd3; ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 3'd3;
    #1;
    vectors++;
    if (stall_out !== 1'b0) begin miscompares++; $display("FAIL load_use_unused_src got %b required 0", stall_out); end
    tick();
    vectors++;
    if (valid_out !== 1'b1) begin miscompares++; $display("FAIL load_use_unused_valid got %b required 1", valid_out); end
    $display("test_load_use done");
    clear_inputs();
  endtask

  task automatic run_multi(input logic [3:0] op, input logic [7:0] m, input logic [2:0] base_r);
    int q[$];
    logic [15:0] base_v, exp_rb;
    logic exp_s;
    clear_inputs();
    opcode_in = op; ra_in = base_r; imm9_in = {1'b0, m}; valid_in = 1'b1;
    regsel_in = 1'b1; pc_in = 16'h0200;
    base_v = m_fwd(base_r);
    for (int b = 0; b < 8; b++) if (m[b]) q.push_back(b);
    exp_s = (q.size() != 0);
    #1;
    vectors++;
    if ({stall_out, lmsm_busy} !== {exp_s, exp_s}) begin
      miscompares++; $display("FAIL multi_accept mask=%h got %b required %b%b", m, {stall_out, lmsm_busy}, exp_s, exp_s);
    end
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL multi_accept_bubble got %b required 0", valid_out); end
    for (int j = 0; j < q.size(); j++) begin
      exp_s = (j < q.size() - 1);
      vectors++;
      if ({stall_out, lmsm_busy} !== {exp_s, 1'b1}) begin
        miscompares++; $display("FAIL multi_stall_%0d got %b required %b1", j, {stall_out, lmsm_busy}, exp_s);
      end
      exp_rb = (op == 4'd7) ? ref_rf[q[j]] : 16'd0;
      tick();
      vectors++;
      if ({valid_out, rc_out, imm_out, ra_data, rb_data, opcode_out} !==
          {1'b1, 3'(q[j]), 16'(2 * j), base_v, exp_rb, op}) begin
        miscompares++;
        $display("FAIL multi_uop_%0d got v=%b rc=%0d imm=%h ra=%h rb=%h op=%0d required 1/%0d/%h/%h/%h/%0d",
                 j, valid_out, rc_out, imm_out, ra_data, rb_data, opcode_out,
                 q[j], 16'(2 * j), base_v, exp_rb, op);
      end
    end
    if (q.size() == 0) begin
      vectors++;
      if (lmsm_busy !== 1'b0) begin miscompares++; $display("FAIL multi_zero_mask_busy got %b required 0", lmsm_busy); end
    end
    clear_inputs();
    #1;
    vectors++;
    if (lmsm_busy !== 1'b0) begin miscompares++; $display("FAIL multi_done_busy got %b required 0", lmsm_busy); end
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL multi_no_extra got %b required 0", valid_out); end
    $display("multi op=%0d mask=%h uops=%0d", op, m, q.size());
  endtask

  task automatic test_lm();
    wb_write(3'd1, 16'h0100);
    run_multi(4'd6, 8'hA5, 3'd1);
    run_multi(4'd6, 8'h00, 3'd1);
    run_multi(4'd6, 8'h80, 3'd1);
  endtask

  task automatic test_sm();
    for (int i = 0; i < 8; i++) wb_write(3'(i), 16'($urandom));
    for (int n = 0; n < 3; n++) run_multi(4'd7, 8'($urandom_range(1, 255)), 3'($urandom_range(0, 7)));
  endtask

  task automatic test_flush();
    wb_write(3'd1, 16'h0100);
    opcode_in = 4'd6; ra_in = 3'd1; imm9_in = 9'h0A5; valid_in = 1'b1; regsel_in = 1'b1;
    tick();
    tick();
    vectors++;
    if ({valid_out, rc_out} !== {1'b1, 3'd0}) begin
      miscompares++; $display("FAIL flush_first_uop got %b/%0d required 1/0", valid_out, rc_out);
    end
    flush = 1'b1;
    #1;
    vectors++;
    if (stall_out !== 1'b0) begin miscompares++; $display("FAIL flush_stall got %b required 0", stall_out); end
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b required 0", valid_out); end
    clear_inputs();
    #1;
    vectors++;
    if ({stall_out, lmsm_busy} !== 2'b00) begin
      miscompares++; $display("FAIL flush_idle got %b required 00", {stall_out, lmsm_busy});
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (valid_out !== 1'b0) begin miscompares++; $display("FAIL flush_no_uop_%0d got %b required 0", c, valid_out); end
    end
    $display("test_flush done");
  endtask

  task automatic test_imm();
    logic [3:0]  ops [5] = '{4'd3, 4'd1, 4'd13, 4'd4, 4'd2};
    logic [5:0]  i6s [5] = '{6'd0, 6'h3F, 6'h3F, 6'h1F, 6'h3F};
    logic [8:0]  i9s [5] = '{9'h1FF, 9'h0, 9'h100, 9'h1FF, 9'h1FF};
    logic [15:0] exps [5] = '{16'h01FF, 16'hFFFF, 16'hFF00, 16'h001F, 16'h0000};
    for (int t = 0; t < 5; t++) begin
      clear_inputs();
      opcode_in = ops[t]; imm6_in = i6s[t]; imm9_in = i9s[t]; valid_in = 1'b1;
      tick();
      vectors++;
      if (imm_out !== exps[t]) begin
        miscompares++; $display("FAIL imm_op%0d got %h required %h", ops[t], imm_out, exps[t]);
      end
      $display("imm op=%0d imm_out=%h", ops[t], imm_out);
    end
    clear_inputs();
  endtask

  task automatic test_hold();
    logic [74:0] exp_o;
    clear_inputs();
    opcode_in = 4'd0; ra_in = 3'd2; rb_in = 3'd3; rc_in = 3'd5; ccz_in = 3'd3;
    pc_in = 16'h1234; regsel_in = 1'b1; valid_in = 1'b1;
    exp_o = {4'd0, 3'd5, m_fwd(3'd2), m_fwd(3'd3), 16'd0, 3'd3, 16'h1234, 1'b1};
    tick();
    en = 1'b0;
    opcode_in = 4'd9; ra_in = 3'd6; rc_in = 3'd1; pc_in = 16'hBEEF; imm6_in = 6'h2A;
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h4444;
    for (int c = 0; c < 3; c++) begin
      tick();
      wb_en = 1'b0;
      vectors++;
      if ({opcode_out, rc_out, ra_data, rb_data, imm_out, ccz_out, pc_out, valid_out} !== exp_o) begin
        miscompares++;
        $display("FAIL hold_cycle%0d got %h required %h", c,
                 {opcode_out, rc_out, ra_data, rb_data, imm_out, ccz_out, pc_out, valid_out}, exp_o);
      end
    end
    ref_rf[4] = 16'h4444;
    en = 1'b1; opcode_in = 4'd0; ra_in = 3'd4;
    tick();
    vectors++;
    if (ra_data !== 16'h4444) begin miscompares++; $display("FAIL hold_wb_write got %h required 4444", ra_data); end
    $display("test_hold done");
    clear_inputs();
  endtask

  task automatic test_reset_multi();
    wb_write(3'd1, 16'h0100);
    opcode_in = 4'd6; ra_in = 3'd1; imm9_in = 9'h0A5; valid_in = 1'b1; regsel_in = 1'b1;
    tick();
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'd0;
    vectors++;
    if ({opcode_out, rc_out, ra_data, rb_data, imm_out, ccz_out, pc_out, valid_out, stall_out, lmsm_busy} !== 77'd0) begin
      miscompares++;
      $display("FAIL reset_multi_outputs got %h required 0",
               {opcode_out, rc_out, ra_data, rb_data, imm_out, ccz_out, pc_out, valid_out, stall_out, lmsm_busy});
    end
    tick();
    vectors++;
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_multi_abort got %b required 0", valid_out); end
    for (int i = 0; i < 8; i++) begin
      opcode_in = 4'd0; ra_in = 3'(i); rb_in = 3'(i); regsel_in = 1'b1; valid_in = 1'b1;
      tick();
      vectors++;
      if ({ra_data, rb_data} !== {ref_rf[i], ref_rf[i]}) begin
        miscompares++; $display("FAIL reset_reg%0d got %h/%h required 0/0", i, ra_data, rb_data);
      end
    end
    $display("test_reset_multi done");
    clear_inputs();
  endtask

  task automatic test_random();
    logic        lu, exp_v;
    logic [73:0] exp_f;
    for (int n = 0; n < 200; n++) begin
      opcode_in = 4'($urandom_range(0, 15));
      if (opcode_in == 4'd6 || opcode_in == 4'd7) opcode_in = 4'd0;
      ra_in = 3'($urandom); rb_in = 3'($urandom); rc_in = 3'($urandom); ccz_in = 3'($urandom);
      imm6_in = 6'($urandom); imm9_in = 9'($urandom); pc_in = 16'($urandom);
      regsel_in = ($urandom_range(0, 4) != 0); valid_in = ($urandom_range(0, 4) != 0);
      wb_en = 1'($urandom); wb_addr = 3'($urandom); wb_data = 16'($urandom);
      ex_wr_en = 1'($urandom); ex_wr_addr = 3'($urandom); ex_wr_data = 16'($urandom);
      ex_is_load = ($urandom_range(0, 3) == 0);
      mem_wr_en = 1'($urandom); mem_wr_addr = 3'($urandom); mem_wr_data = 16'($urandom);
      lu = m_load_use();
      exp_v = valid_in && !lu;
      exp_f = {opcode_in, rc_in, regsel_in ? m_fwd(ra_in) : 16'd0, regsel_in ? m_fwd(rb_in) : 16'd0,
               m_imm(opcode_in, imm6_in, imm9_in), ccz_in, pc_in};
      #1;
      vectors++;
      if (stall_out !== lu) begin miscompares++; $display("FAIL rand%0d_stall got %b required %b", n, stall_out, lu); end
      tick();
      if (wb_en) ref_rf[wb_addr] = wb_data;
      vectors++;
      if (valid_out !== exp_v) begin
        miscompares++; $display("FAIL rand%0d_valid got %b required %b", n, valid_out, exp_v);
      end
      if (exp_v) begin
        vectors++;
        if ({opcode_out, rc_out, ra_data, rb_data, imm_out, ccz_out, pc_out} !== exp_f) begin
          miscompares++;
          $display("FAIL rand%0d_fields got %h required %h", n,
                   {opcode_out, rc_out, ra_data, rb_data, imm_out, ccz_out, pc_out}, exp_f);
        end
      end
    end
    $display("test_random done");
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_lm();
    test_sm();
    test_flush();
    test_imm();
    test_hold();
    test_reset_multi();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_read_stage.md
REG_READ_STAGE -- requirements
Module: reg_read_stage

Interface
REQ-001 SHALL have input `clk`, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have input `rst`, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have inputs `en`, `flush`, `valid_in`, each 1 bit: pipeline enable, kill, and decode-output valid.
REQ-004 SHALL have decoded-field inputs: `opcode_in` (4), `ra_in` (3), `rb_in` (3), `rc_in` (3), `imm6_in` (6), `imm9_in` (9), `ccz_in` (3), `pc_in` (16), `regsel_in` (1).
REQ-005 SHALL have writeback inputs `wb_en` (1), `wb_addr` (3), `wb_data` (16).
REQ-006 SHALL have EX forwarding inputs `ex_wr_en` (1), `ex_wr_addr` (3), `ex_wr_data` (16), `ex_is_load` (1).
REQ-007 SHALL have MEM forwarding inputs `mem_wr_en` (1), `mem_wr_addr` (3), `mem_wr_data` (16).
REQ-008 SHALL have registered outputs: `opcode_out` (4), `rc_out` (3), `ra_data` (16), `rb_data` (16), `imm_out` (16), `ccz_out` (3), `pc_out` (16), `valid_out` (1).
REQ-009 SHALL have outputs `stall_out` (1), which holds upstream stages, and `lmsm_busy` (1), which is high during a multi-register sequence.

Function
REQ-010 SHALL contain an 8x16 register file; on `wb_en`, `wb_addr` is written at the clock edge regardless of `en`.
REQ-011 SHALL resolve each source operand by priority: EX match, then MEM match, then WB match, then file. A match requires the write enable plus equal address.
REQ-012 SHALL force `ra_data`/`rb_data` to 0 when `regsel_in`=0.
REQ-013 SHALL build `imm_out` per opcode:
- sign-extended `imm6` for 1, 4, 5, 8, 9, 10, 12;
- zero-extended `imm9` for 3;
- sign-extended `imm9` for 13;
- 0 otherwise.
REQ-014 SHALL have a latency of 1 cycle: an accepted input appears on the outputs the next cycle.
REQ-015 SHALL detect load-use: `ex_is_load` and `ex_wr_en` and `ex_wr_addr` equal to a source actually read by `opcode_in` (`ra` for 0, 1, 2, 5, 6, 7, 8, 9, 10, 13; `rb` for 0, 2, 4, 5, 8, 9, 10, 12).
REQ-016 SHALL, on load-use, emit a bubble (`valid_out`=0), assert `stall_out` combinationally, and not consume the input. Re-evaluation occurs the next cycle.
REQ-017 SHALL implement an FSM with states IDLE and MULTI.
REQ-018 SHALL enter MULTI on an accepted LM (6) or SM (7) whose `imm9_in[7:0]` is nonzero. It latches the mask, base (resolved `ra`), opcode, and pc, and sets k=0.
REQ-019 SHALL, in each MULTI cycle:
- select the lowest set mask bit i, emit one micro-op (`valid_out`=1, `rc_out`=i, `ra_data`=base, `imm_out`=2*k, `rb_data`=forwarded Ri for SM), then clear bit i and increment k;
- return to IDLE after emitting the last bit.
REQ-020 SHALL hold `stall_out` and `lmsm_busy` high from LM/SM acceptance until the cycle emitting the final micro-op. `stall_out` is low in that final cycle.
REQ-021 SHALL treat LM/SM with mask 0 as a single bubble (`valid_out`=0) with no MULTI entry.
REQ-022 SHALL hold all outputs and state when `en`=0, unless `flush`=1.
REQ-023 SHALL give `flush` priority over `en`, stall, and MULTI: next cycle `valid_out`=0, FSM goes to IDLE, the latched mask is cleared, and `stall_out` is 0.
REQ-024 SHALL emit `valid_out`=0 for an accepted cycle with `valid_in`=0.
REQ-025 SHALL keep a WB write to Ri in the same cycle as a read of Ri visible via forwarding (write-through).

Reset
REQ-026 SHALL, on `rst`, zero all outputs, all eight registers, the mask, and k, and set the FSM to IDLE. `rst` has priority over `flush` and `en`.
REQ-027 SHALL abort a MULTI sequence on `rst` mid-sequence with no further micro-ops.

Verification
REQ-028 SHALL cover forwarding: R2=5 in file, `mem` writes R2=7, `ex` writes R2=9, ADD `ra`=2 -> `ra_data`=9; drop `ex` -> 7; drop both -> 5.
REQ-029 SHALL cover load-use: `ex_is_load`, `ex_wr_addr`=3, ADD `rb`=3 -> one bubble and `stall_out`=1 for one cycle; next cycle (no load) valid ADD.
REQ-030 SHALL cover LM: `imm9`=0x0A5, base R1=0x100 -> micro-ops `rc_out`=0, 2, 5, 7 with `imm_out`=0, 2, 4, 6 on four consecutive cycles; `stall_out` high on the first three.
REQ-031 SHALL cover flush: flush during the 2nd LM micro-op -> `valid_out`=0 next cycle, IDLE, no remaining micro-ops.
REQ-032 SHALL cover immediates: LLI `imm9`=0x1FF -> `imm_out`=0x01FF; ADI `imm6`=0x3F -> 0xFFFF; JRI `imm9`=0x100 -> 0xFF00.
REQ-033 SHALL cover reset and hold: `rst` during MULTI -> all outputs 0, registers read 0; `en`=0 for 3 cycles -> outputs unchanged.
